// File: rtl/memory_access_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Word-wide req/ack handshake; ack is a single-cycle pulse that qualifies rdata.
interface memory_access_if;
    localparam int unsigned XLEN = 32;

    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o;
    logic [XLEN-1:0] dmem_wdata_o;
    logic            dmem_ack_i;
    logic [XLEN-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_wdata_o,
        input  dmem_ack_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_wdata_o,
        output dmem_ack_i,
        output dmem_rdata_i
    );
endinterface

// File: rtl/memory_access.sv
// MEM stage of the RV32 pipeline: word loads/stores over the req/ack data bus,
// pipeline stall while an access is outstanding, misalignment and timeout traps.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                PIP_write_mem_i,
    input  logic                PIP_read_mem_i,
    input  logic [31:0]         PIP_alu_result_i,
    input  logic [31:0]         PIP_second_operand_i,
    input  logic                PIP_use_mem_i,
    input  logic                PIP_write_reg_i,
    input  logic [4:0]          PIP_rd_i,
    input  logic                PIP_TRAP_i,
    memory_access_if.master     dmem,
    output logic                stall_o,
    output logic [31:0]         PIP_mem_data_o,
    output logic [31:0]         PIP_alu_result_o,
    output logic                PIP_use_mem_o,
    output logic                PIP_write_reg_o,
    output logic [4:0]          PIP_rd_o,
    output logic                PIP_TRAP_o
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             mem_op;
    logic             misalign;
    logic             timeout;

    assign mem_op   = (PIP_read_mem_i | PIP_write_mem_i) & ~PIP_TRAP_i;
    assign misalign = mem_op & (PIP_alu_result_i[1:0] != 2'b00);
    assign timeout  = (state == BUSY) & (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

    // In BUSY the stall releases on ack or timeout, so EX/MEM advances on the same edge MEM/WB loads.
    assign stall_o = ~reset & ((state == IDLE) ? (mem_op & ~misalign)
                                               : (~dmem.dmem_ack_i & ~timeout));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            tmo_cnt           <= '0;
            dmem.dmem_req_o   <= 1'b0;
            dmem.dmem_we_o    <= 1'b0;
            dmem.dmem_addr_o  <= '0;
            dmem.dmem_wdata_o <= '0;
            PIP_mem_data_o    <= '0;
            PIP_alu_result_o  <= '0;
            PIP_use_mem_o     <= 1'b0;
            PIP_write_reg_o   <= 1'b0;
            PIP_rd_o          <= '0;
            PIP_TRAP_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op && !misalign) begin
                        // Launch the access; MEM/WB sees a bubble with rd = 0 so nothing forwards.
                        state             <= BUSY;
                        tmo_cnt           <= '0;
                        dmem.dmem_req_o   <= 1'b1;
                        dmem.dmem_we_o    <= PIP_write_mem_i;
                        dmem.dmem_addr_o  <= {PIP_alu_result_i[31:2], 2'b00};
                        dmem.dmem_wdata_o <= PIP_second_operand_i;
                        PIP_mem_data_o    <= '0;
                        PIP_alu_result_o  <= '0;
                        PIP_use_mem_o     <= 1'b0;
                        PIP_write_reg_o   <= 1'b0;
                        PIP_rd_o          <= '0;
                        PIP_TRAP_o        <= 1'b0;
                    end else begin
                        PIP_mem_data_o    <= '0;
                        PIP_alu_result_o  <= PIP_alu_result_i;
                        PIP_use_mem_o     <= PIP_use_mem_i;
                        PIP_write_reg_o   <= PIP_write_reg_i & ~misalign;
                        PIP_rd_o          <= PIP_rd_i;
                        PIP_TRAP_o        <= PIP_TRAP_i | misalign;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack_i) begin
                        state             <= IDLE;
                        dmem.dmem_req_o   <= 1'b0;
                        PIP_mem_data_o    <= dmem.dmem_we_o ? 32'h0 : dmem.dmem_rdata_i;
                        PIP_alu_result_o  <= PIP_alu_result_i;
                        PIP_use_mem_o     <= PIP_use_mem_i;
                        PIP_write_reg_o   <= PIP_write_reg_i;
                        PIP_rd_o          <= PIP_rd_i;
                        PIP_TRAP_o        <= PIP_TRAP_i;
                    end else if (timeout) begin
                        // Abort: the instruction retires as a trap without a register write.
                        state             <= IDLE;
                        dmem.dmem_req_o   <= 1'b0;
                        PIP_mem_data_o    <= '0;
                        PIP_alu_result_o  <= PIP_alu_result_i;
                        PIP_use_mem_o     <= 1'b0;
                        PIP_write_reg_o   <= 1'b0;
                        PIP_rd_o          <= PIP_rd_i;
                        PIP_TRAP_o        <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: table of single-cycle pass-through vectors
// plus hand-written load/store/timeout/reset sequences against a scripted bus slave.
module tb_memory_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        PIP_write_mem_i, PIP_read_mem_i;
    logic [31:0] PIP_alu_result_i, PIP_second_operand_i;
    logic        PIP_use_mem_i, PIP_write_reg_i;
    logic [4:0]  PIP_rd_i;
    logic        PIP_TRAP_i;
    logic        stall_o;
    logic [31:0] PIP_mem_data_o, PIP_alu_result_o;
    logic        PIP_use_mem_o, PIP_write_reg_o;
    logic [4:0]  PIP_rd_o;
    logic        PIP_TRAP_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memory_access_if bus();

    memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .PIP_write_mem_i      (PIP_write_mem_i),
        .PIP_read_mem_i       (PIP_read_mem_i),
        .PIP_alu_result_i     (PIP_alu_result_i),
        .PIP_second_operand_i (PIP_second_operand_i),
        .PIP_use_mem_i        (PIP_use_mem_i),
        .PIP_write_reg_i      (PIP_write_reg_i),
        .PIP_rd_i             (PIP_rd_i),
        .PIP_TRAP_i           (PIP_TRAP_i),
        .dmem                 (bus.master),
        .stall_o              (stall_o),
        .PIP_mem_data_o       (PIP_mem_data_o),
        .PIP_alu_result_o     (PIP_alu_result_o),
        .PIP_use_mem_o        (PIP_use_mem_o),
        .PIP_write_reg_o      (PIP_write_reg_o),
        .PIP_rd_o             (PIP_rd_o),
        .PIP_TRAP_o           (PIP_TRAP_o)
    );

    typedef struct {
        logic        wr;
        logic        rdm;
        logic [31:0] alu;
        logic [31:0] op2;
        logic        use_mem;
        logic        wreg;
        logic [4:0]  rd;
        logic        trap;
        logic        e_wreg;
        logic [4:0]  e_rd;
        logic [31:0] e_alu;
        logic        e_use_mem;
        logic        e_trap;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rdm, input logic [31:0] alu,
                         input logic [31:0] op2, input logic use_mem, input logic wreg,
                         input logic [4:0] rd, input logic trap);
        PIP_write_mem_i      = wr;
        PIP_read_mem_i       = rdm;
        PIP_alu_result_i     = alu;
        PIP_second_operand_i = op2;
        PIP_use_mem_i        = use_mem;
        PIP_write_reg_i      = wreg;
        PIP_rd_i             = rd;
        PIP_TRAP_i           = trap;
    endtask

    task automatic clear_in();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Called at posedge+1 with the memory instruction on the inputs; acks on the
    // (wait_n+1)-th request cycle and returns just after the edge that releases the stall.
    task automatic run_mem(input int wait_n, input logic [31:0] rdata,
                           output int n_st, output int n_rq,
                           output logic [31:0] s_addr, output logic [31:0] s_wdata,
                           output logic s_we, output logic done);
        logic st;
        n_st = 0; n_rq = 0; done = 1'b0;
        s_addr = 32'h0; s_wdata = 32'h0; s_we = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            bus.dmem_ack_i   = bus.dmem_req_o && (n_rq == wait_n);
            bus.dmem_rdata_i = bus.dmem_ack_i ? rdata : 32'hBAD0BAD0;
            #1;
            if (bus.dmem_req_o) begin
                if (n_rq == 0) begin
                    s_addr  = bus.dmem_addr_o;
                    s_wdata = bus.dmem_wdata_o;
                    s_we    = bus.dmem_we_o;
                end
                n_rq++;
            end
            st = stall_o;
            if (st) n_st++;
            @(posedge clk); #1;
            bus.dmem_ack_i = 1'b0;
            if (!st) done = 1'b1;
        end
    endtask

    initial begin
        int n_st, n_rq;
        logic [31:0] s_addr, s_wdata;
        logic s_we, done;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0,
                    1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0102, 32'h0, 1'b1, 1'b1, 5'd7, 1'b0,
                    1'b0, 5'd7, 32'h0000_0102, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0201, 32'hAA, 1'b0, 1'b0, 5'd0, 1'b0,
                    1'b0, 5'd0, 32'h0000_0201, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 5'd2, 1'b1,
                    1'b1, 5'd2, 32'h0000_0100, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0,
                    1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0003, 32'h0, 1'b0, 1'b1, 5'd8, 1'b0,
                    1'b0, 5'd8, 32'h0000_0003, 1'b0, 1'b1};

        reset = 1'b1;
        clear_in();
        bus.dmem_ack_i   = 1'b0;
        bus.dmem_rdata_i = 32'h0;
        #12;
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_req", 32'(bus.dmem_req_o), 32'h0);
        chk("rst_wreg", 32'(PIP_write_reg_o), 32'h0);
        chk("rst_alu", PIP_alu_result_o, 32'h0);
        chk("rst_trap", 32'(PIP_TRAP_o), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single-cycle pass-through vectors.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].wr, vecs[i].rdm, vecs[i].alu, vecs[i].op2,
                  vecs[i].use_mem, vecs[i].wreg, vecs[i].rd, vecs[i].trap);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'h0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_req", i), 32'(bus.dmem_req_o), 32'h0);
            chk($sformatf("v%0d_wreg", i), 32'(PIP_write_reg_o), 32'(vecs[i].e_wreg));
            chk($sformatf("v%0d_rd", i), 32'(PIP_rd_o), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_alu", i), PIP_alu_result_o, vecs[i].e_alu);
            chk($sformatf("v%0d_usemem", i), 32'(PIP_use_mem_o), 32'(vecs[i].e_use_mem));
            chk($sformatf("v%0d_trap", i), 32'(PIP_TRAP_o), 32'(vecs[i].e_trap));
            chk($sformatf("v%0d_mdata", i), PIP_mem_data_o, 32'h0);
        end

        // Load 0x100, ack three cycles after req rises.
        drive(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b1, 5'd3, 1'b0);
        run_mem(3, 32'hDEAD_BEEF, n_st, n_rq, s_addr, s_wdata, s_we, done);
        chk("ld_done", 32'(done), 32'h1);
        chk("ld_stall_cycles", 32'(n_st), 32'd4);
        chk("ld_req_cycles", 32'(n_rq), 32'd4);
        chk("ld_addr", s_addr, 32'h0000_0100);
        chk("ld_we", 32'(s_we), 32'h0);
        chk("ld_mdata", PIP_mem_data_o, 32'hDEAD_BEEF);
        chk("ld_usemem", 32'(PIP_use_mem_o), 32'h1);
        chk("ld_wreg", 32'(PIP_write_reg_o), 32'h1);
        chk("ld_rd", 32'(PIP_rd_o), 32'd3);
        chk("ld_req_after", 32'(bus.dmem_req_o), 32'h0);
        clear_in();

        // Store with zero-wait ack.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 1'b0, 5'd0, 1'b0);
        run_mem(0, 32'h1234_5678, n_st, n_rq, s_addr, s_wdata, s_we, done);
        chk("st_done", 32'(done), 32'h1);
        chk("st_stall_cycles", 32'(n_st), 32'd1);
        chk("st_req_cycles", 32'(n_rq), 32'd1);
        chk("st_we", 32'(s_we), 32'h1);
        chk("st_addr", s_addr, 32'h0000_0200);
        chk("st_wdata", s_wdata, 32'hCAFE_F00D);
        chk("st_wreg", 32'(PIP_write_reg_o), 32'h0);
        chk("st_mdata", PIP_mem_data_o, 32'h0);
        clear_in();

        // Load with no ack: times out after 5 BUSY cycles at TIMEOUT_CYCLES = 4.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b1, 1'b1, 5'd4, 1'b0);
        run_mem(1000, 32'h0, n_st, n_rq, s_addr, s_wdata, s_we, done);
        chk("to_done", 32'(done), 32'h1);
        chk("to_req_cycles", 32'(n_rq), 32'd5);
        chk("to_stall_cycles", 32'(n_st), 32'd5);
        chk("to_trap", 32'(PIP_TRAP_o), 32'h1);
        chk("to_wreg", 32'(PIP_write_reg_o), 32'h0);
        chk("to_req_after", 32'(bus.dmem_req_o), 32'h0);
        clear_in();
        bus.dmem_ack_i   = 1'b1;
        bus.dmem_rdata_i = 32'h7777_7777;
        #1;
        chk("stray_stall", 32'(stall_o), 32'h0);
        @(posedge clk); #1;
        bus.dmem_ack_i = 1'b0;
        chk("stray_req", 32'(bus.dmem_req_o), 32'h0);
        chk("stray_mdata", PIP_mem_data_o, 32'h0);
        chk("stray_trap", 32'(PIP_TRAP_o), 32'h0);

        // Reset in the middle of a BUSY load.
        drive(1'b0, 1'b1, 32'h0000_0500, 32'h0, 1'b1, 1'b1, 5'd6, 1'b0);
        @(posedge clk); #1;
        chk("rb_req_up", 32'(bus.dmem_req_o), 32'h1);
        reset = 1'b1;
        #1;
        chk("rb_req", 32'(bus.dmem_req_o), 32'h0);
        chk("rb_stall", 32'(stall_o), 32'h0);
        chk("rb_addr", bus.dmem_addr_o, 32'h0);
        clear_in();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.dmem_ack_i   = 1'b1;
        bus.dmem_rdata_i = 32'h1111_1111;
        @(posedge clk); #1;
        bus.dmem_ack_i = 1'b0;
        chk("rb_ack_ignored", PIP_mem_data_o, 32'h0);
        chk("rb_wreg", 32'(PIP_write_reg_o), 32'h0);

        drive(1'b0, 1'b1, 32'h0000_0300, 32'h0, 1'b1, 1'b1, 5'd9, 1'b0);
        run_mem(1, 32'h0BAD_F00D, n_st, n_rq, s_addr, s_wdata, s_we, done);
        chk("rl_done", 32'(done), 32'h1);
        chk("rl_stall_cycles", 32'(n_st), 32'd2);
        chk("rl_req_cycles", 32'(n_rq), 32'd2);
        chk("rl_addr", s_addr, 32'h0000_0300);
        chk("rl_mdata", PIP_mem_data_o, 32'h0BAD_F00D);
        chk("rl_rd", 32'(PIP_rd_o), 32'd9);
        clear_in();

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
